// File: rtl/i2c_scl_generator.sv
// i2c_scl_generator
//
// Generates the I2C SCL waveform from the system clock with a runtime
// programmable half-period, plus phase strobes and a byte/ACK bit counter
// for the I2C master datapath. Optional clock stretching (slave holding SCL
// low) is built when the macro I2C_SCL_STRETCH_EN is defined.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   en         run request (level)
//   div        requested half-period H in clk cycles (clamped to >= 2)
//   scl_in     sensed SCL pad level (async; used only with stretching)
//   scl        SCL level driven (1 = released)
//   scl_oe     pad pull-down enable (= ~scl)
//   scl_fall   first cycle with scl = 0
//   scl_rise   first cycle with scl = 1 after a low phase
//   scl_drive  low-phase midpoint (SDA may change)
//   scl_sample high-phase midpoint (SDA sampled)
//   bit_idx    bit slot 0..8 (8 = ACK)
//   byte_done  bit_idx wrapped 8 -> 0 (coincident with scl_fall)
//   busy       not idle
//   stretching high phase held by a low synchronised scl_in
//   dbg_state  FSM state (0 idle, 1 low, 2 high)
//
// Control semantics: en is a level, not a valid/ready handshake. It is
// sampled at every clock edge in IDLE and at the last counted cycle of each
// high phase; a cycle in progress is always completed, so dropping en never
// truncates SCL and the line is always left released. All strobes are
// registered and exactly one cycle wide.
module i2c_scl_generator #(
  parameter int                DIV_W       = 8,
  parameter logic [DIV_W-1:0]  DIV_DEFAULT = DIV_W'(4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             scl_in,
  output logic             scl,
  output logic             scl_oe,
  output logic             scl_fall,
  output logic             scl_rise,
  output logic             scl_drive,
  output logic             scl_sample,
  output logic [3:0]       bit_idx,
  output logic             byte_done,
  output logic             busy,
  output logic             stretching,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] h_q, h_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic             scl_q, scl_d;
  logic             scl_oe_q, scl_oe_d;
  logic             fall_q, fall_d;
  logic             rise_q, rise_d;
  logic             drive_q, drive_d;
  logic             sample_q, sample_d;
  logic             byte_done_q, byte_done_d;
  logic             busy_q, busy_d;
  logic             stretching_q, stretching_d;

  logic [DIV_W-1:0] div_clamped;
  logic             phase_end;
  // scl_in_s is the synchronised pad level this cycle; scl_in_s_next is
  // what it will be next cycle, used to build the registered outputs.
  logic             scl_in_s;
  logic             scl_in_s_next;

`ifdef I2C_SCL_STRETCH_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = scl_in;
    sync2_d = sync1_q;
  end

  // Synchroniser resets to "released" so an idle bus is not seen as held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign scl_in_s      = sync2_q;
  assign scl_in_s_next = sync1_q;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign scl_in_s      = 1'b1;
  assign scl_in_s_next = 1'b1;
`endif

  assign div_clamped = (div < DIV_W'(2)) ? DIV_W'(2) : div;
  assign phase_end   = (cnt_q == (h_q - DIV_W'(1)));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    h_d         = h_q;
    bit_idx_d   = bit_idx_q;
    fall_d      = 1'b0;
    rise_d      = 1'b0;
    byte_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_LOW;
          cnt_d     = '0;
          h_d       = div_clamped;
          bit_idx_d = 4'd0;
          fall_d    = 1'b1;
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          h_d     = div_clamped;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        // Only cycles with the pad seen high count towards the high phase.
        if (scl_in_s) begin
          if (phase_end) begin
            cnt_d = '0;
            if (en) begin
              state_d     = ST_LOW;
              h_d         = div_clamped;
              fall_d      = 1'b1;
              byte_done_d = (bit_idx_q == 4'd8);
              bit_idx_d   = (bit_idx_q == 4'd8) ? 4'd0 : bit_idx_q + 4'd1;
            end else begin
              state_d   = ST_IDLE;
              bit_idx_d = 4'd0;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        bit_idx_d = 4'd0;
      end
    endcase

    // Outputs are registered, so they are derived from next-cycle values.
    scl_d        = (state_d != ST_LOW);
    scl_oe_d     = (state_d == ST_LOW);
    busy_d       = (state_d != ST_IDLE);
    drive_d      = (state_d == ST_LOW) && (cnt_d == (h_d >> 1));
    // A held count must not repeat the sample strobe: require a counted cycle.
    sample_d     = (state_d == ST_HIGH) && (cnt_d == (h_d >> 1)) && scl_in_s_next;
    stretching_d = (state_d == ST_HIGH) && !scl_in_s_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      h_q          <= DIV_DEFAULT;
      bit_idx_q    <= 4'd0;
      scl_q        <= 1'b1;
      scl_oe_q     <= 1'b0;
      fall_q       <= 1'b0;
      rise_q       <= 1'b0;
      drive_q      <= 1'b0;
      sample_q     <= 1'b0;
      byte_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      stretching_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      h_q          <= h_d;
      bit_idx_q    <= bit_idx_d;
      scl_q        <= scl_d;
      scl_oe_q     <= scl_oe_d;
      fall_q       <= fall_d;
      rise_q       <= rise_d;
      drive_q      <= drive_d;
      sample_q     <= sample_d;
      byte_done_q  <= byte_done_d;
      busy_q       <= busy_d;
      stretching_q <= stretching_d;
    end
  end

  assign scl        = scl_q;
  assign scl_oe     = scl_oe_q;
  assign scl_fall   = fall_q;
  assign scl_rise   = rise_q;
  assign scl_drive  = drive_q;
  assign scl_sample = sample_q;
  assign bit_idx    = bit_idx_q;
  assign byte_done  = byte_done_q;
  assign busy       = busy_q;
  assign stretching = stretching_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_scl_generator.sv
// Testbench for i2c_scl_generator.
// Each burst is planned as a per-cycle table of inputs and expected outputs
// computed from the waveform rules (phase lengths, strobe offsets, bit slot
// = cycle number mod 9). The driver plays the table and pushes expectations
// into exp_q; an independent monitor pops and compares on the falling edge.
module tb_i2c_scl_generator;
  localparam int W = 13;
`ifdef I2C_SCL_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif
  // {scl, scl_oe, fall, rise, drive, sample, bit_idx[3:0], byte_done, busy, stretching}
  localparam logic [W-1:0] IDLE_V = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div = 8'd4;
  logic       scl_in = 1'b1;
  logic       scl, scl_oe, scl_fall, scl_rise, scl_drive, scl_sample;
  logic [3:0] bit_idx;
  logic       byte_done, busy, stretching;
  logic [1:0] dbg_state;

  i2c_scl_generator #(.DIV_W(8), .DIV_DEFAULT(8'd4)) dut (
    .clk(clk), .rst(rst), .en(en), .div(div), .scl_in(scl_in),
    .scl(scl), .scl_oe(scl_oe), .scl_fall(scl_fall), .scl_rise(scl_rise),
    .scl_drive(scl_drive), .scl_sample(scl_sample), .bit_idx(bit_idx),
    .byte_done(byte_done), .busy(busy), .stretching(stretching),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic         tr_en[$];
  logic [7:0]   tr_div[$];
  logic         tr_sin[$];
  logic [W-1:0] tr_exp[$];

  function automatic logic [W-1:0] mk(input bit s, input bit f, input bit r, input bit d,
                                      input bit sm, input int bi, input bit bd,
                                      input bit bz, input bit st);
    logic [3:0] b;
    b = 4'(bi);
    return {s, ~s, f, r, d, sm, b, bd, bz, st};
  endfunction

  function automatic int clamp2(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int rnd_div();
    return int'($urandom_range(255, 0));
  endfunction

  task automatic check(input string nm, input logic [W-1:0] e);
    logic [W-1:0] a;
    a = {scl, scl_oe, scl_fall, scl_rise, scl_drive, scl_sample, bit_idx, byte_done, busy, stretching};
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %b expected %b (scl oe fall rise drive sample bit_idx byte_done busy stretching)",
               nm, cyc, a, e);
    end
  endtask

  task automatic push_cyc(input bit e, input int dv, input bit si, input logic [W-1:0] ev);
    tr_en.push_back(e);
    tr_div.push_back(8'(dv));
    tr_sin.push_back(si);
    tr_exp.push_back(ev);
  endtask

  // Plan a burst of n SCL cycles. dv >= 0 fixes every phase's half-period,
  // otherwise each phase gets a random one. div carries the chosen value only
  // in the cycle before a phase starts and random junk elsewhere. drop >= 0
  // places the en drop at that offset into the last SCL cycle. dh0 >= 0
  // overrides the first high phase's half-period.
  task automatic gen_burst(input int n, input int dv, input int drop, input int dh0);
    int dl[$];
    int dh[$];
    int x, s, hl, hh, fol, last, dp, g, nx;
    tr_en.delete(); tr_div.delete(); tr_sin.delete(); tr_exp.delete();
    for (int k = 0; k < n; k++) begin
      dl.push_back((dv >= 0) ? dv : int'($urandom_range(9, 0)));
      dh.push_back((dv >= 0) ? dv : int'($urandom_range(9, 0)));
    end
    if (dh0 >= 0) dh[0] = dh0;
    // x cycles of extra slave hold after each release; the sync adds 2 more.
    x   = STRETCH ? int'($urandom_range(3, 0)) : 0;
    s   = STRETCH ? x + 2 : 0;
    fol = 0;
    push_cyc(1'b1, dl[0], 1'b1, IDLE_V);
    for (int k = 0; k < n; k++) begin
      hl = clamp2(dl[k]);
      hh = clamp2(dh[k]);
      if (k == n - 1) fol = tr_en.size();
      for (int j = 0; j < hl; j++) begin
        nx = (j == hl - 1) ? dh[k] : rnd_div();
        push_cyc(1'b1, nx, 1'b0,
                 mk(1'b0, j == 0, 1'b0, j == (hl / 2), 1'b0, k % 9,
                    (j == 0) && (k > 0) && (k % 9 == 0), 1'b1, 1'b0));
      end
      for (int j = 0; j < hh + s; j++) begin
        nx = ((j == hh + s - 1) && (k < n - 1)) ? dl[k + 1] : rnd_div();
        push_cyc(1'b1, nx, j >= x,
                 mk(1'b1, 1'b0, j == 0, 1'b0, j == s + (hh / 2), k % 9, 1'b0, 1'b1, j < s));
      end
    end
    last = tr_en.size() - 1;
    dp = (drop >= 0) ? fol + drop : int'($urandom_range(last, fol));
    for (int i = dp; i <= last; i++) tr_en[i] = 1'b0;
    g = int'($urandom_range(3, 1));
    for (int i = 0; i < g; i++) push_cyc(1'b0, rnd_div(), 1'b1, IDLE_V);
  endtask

  // ---------------- driver ----------------
  task automatic play(input int limit);
    for (int i = 0; i < tr_en.size() && i < limit; i++) begin
      @(posedge clk);
      #1;
      en     = tr_en[i];
      div    = tr_div[i];
      scl_in = tr_sin[i];
      exp_q.push_back(tr_exp[i]);
      cyc++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(IDLE_V);
      cyc++;
    end
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb", e);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int p, k;
    // Reset state while held in reset.
    idle_cycles(3);
    @(posedge clk);
    #3 rst = 1'b1;
    idle_cycles(2);

    gen_burst(2, 4, -1, -1);  play(1 << 30);   // nominal 8-cycle period
    gen_burst(3, 0, -1, -1);  play(1 << 30);   // clamp to 2
    gen_burst(2, 0, -1, 6);   play(1 << 30);   // retune 0 -> 6 mid-low
    gen_burst(1, 4, 2, -1);   play(1 << 30);   // stop at scl_drive
    gen_burst(10, 4, -1, -1); play(1 << 30);   // byte framing

    // Reset in the low phase of bit slot 5.
    gen_burst(7, 4, -1, -1);
    p = 8 + (tr_en.size() > 0 ? 0 : 0);
    k = 0;
    // locate the 6th falling edge (bit slot 5) in the planned table
    for (int i = 0; i < tr_exp.size(); i++) begin
      if (tr_exp[i][10] === 1'b1) begin
        if (k == 5) begin p = i; break; end
        k++;
      end
    end
    play(p + 2);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_mid", IDLE_V);
    en = 1'b0;
    idle_cycles(2);
    @(posedge clk);
    #3 rst = 1'b1;
    gen_burst(2, 4, -1, -1);  play(1 << 30);   // first run after reset

    for (int r = 0; r < 20; r++) begin
      gen_burst(int'($urandom_range(12, 1)), -1, -1, -1);
      play(1 << 30);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #6;
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    report();
    $finish;
  end

endmodule

// File: doc/i2c_scl_generator.md
# i2c_scl_generator

Parametrised I2C SCL generator with a runtime-programmable half-period, start/stop control, phase strobes for the I2C master datapath, a 9-bit (byte + ACK) bit counter, and optional clock stretching. It replaces the fixed divide-by-4 SCL divider. It sits between the system clock domain and the open-drain SCL pad, and feeds timing strobes to the I2C master FSM and shifter.

## Interface
- DIV_W, 8: width of the half-period divisor input.
- DIV_DEFAULT, 8'd4: half-period used while `div` has not yet been sampled after reset (must fit in DIV_W bits).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset. **Asynchronous, active-low.**
- `en` in 1: run request. Level-sensitive.
- `div` in DIV_W: requested half-period H, in `clk` cycles.
- `scl_in` in 1: sensed SCL pad level, asynchronous to `clk`. Used only with stretching.
- `scl` out 1: SCL level driven by this block. 1 = released, 0 = pulled low.
- `scl_oe` out 1: pad pull-down enable, always equal to `~scl`.
- `scl_fall` out 1: single-cycle pulse in the first cycle `scl` is 0.
- `scl_rise` out 1: single-cycle pulse in the first cycle `scl` is 1 (released).
- `scl_drive` out 1: pulse at the low-phase midpoint, where SDA may change.
- `scl_sample` out 1: pulse at the high-phase midpoint, where SDA is sampled.
- `bit_idx` out 4: current bit slot, 0..8 (8 = ACK).
- `byte_done` out 1: pulse when `bit_idx` wraps from 8 to 0.
- `busy` out 1: state ≠ IDLE.
- `stretching` out 1: high phase held because the synchronised `scl_in` is low.

## Operation
- **States and transitions:**
  - IDLE: `scl`=1. Moves to LOW when `en`=1.
  - LOW: `scl`=0 for H cycles. Moves to HIGH.
  - HIGH: `scl`=1 for H counted cycles. Moves to LOW if `en`=1, otherwise to IDLE.
- **Half-period H:**
  - `div` is latched into `h_q` on entry to each LOW and each HIGH phase.
  - Values below 2 clamp to 2, so H = max(`div`, 2).
  - Changing `div` mid-phase has no effect until the next phase boundary.
- **Phase counter:** `cnt` (DIV_W bits) runs 0..H−1 within a phase and is cleared on every state change.
  - `scl_drive` fires in LOW when `cnt` == H>>1.
  - `scl_sample` fires in HIGH when `cnt` == H>>1, as a counted cycle.
- **Stopping:** deasserting `en` never truncates a cycle.
  - In LOW, the block finishes LOW and the full HIGH phase, then enters IDLE.
  - In HIGH, it finishes HIGH, then enters IDLE.
  - SCL is therefore always left released.
- **Bit counter:**
  - Leaving IDLE sets `bit_idx`=0. The first `scl_fall` after IDLE does not increment it.
  - Each later `scl_fall` increments it modulo 9. On 8→0, `byte_done` pulses in the same cycle as `scl_fall`.
  - Entering IDLE clears `bit_idx` to 0.
- **Reset values (`rst`=0, asynchronous):**
  - State IDLE, `cnt`=0, `h_q`=DIV_DEFAULT, synchroniser flops=1.
  - `scl`=1, `scl_oe`=0.
  - `scl_fall`, `scl_rise`, `scl_drive`, `scl_sample`, `byte_done`, `busy`, `stretching` = 0.
  - `bit_idx`=0.
- **Reset asserted mid-operation:** the block forces the values above immediately, with no completion of the current cycle. The first run after release starts cleanly from IDLE.

## Timing
- All outputs are registered. Strobes are exactly 1 cycle wide.
- **Start latency:** `en` sampled high in cycle t gives `scl`=0 and `scl_fall`=1 in cycle t+1.
- **Without stretching:**
  - Low phase = H cycles, high phase = H cycles, period = 2H.
  - Relative to `scl_fall` at t0: `scl_drive` at t0+(H>>1), `scl_rise` at t0+H, `scl_sample` at t0+H+(H>>1).
- **With stretching:**
  - `scl_in` passes through a 2-flop synchroniser, giving `scl_in_s`.
  - In HIGH, `cnt` holds at its value while `scl_in_s`=0.
  - Nominal high phase = H+2 cycles, because synchroniser latency is counted as stretch.
  - `stretching` = (state==HIGH) & ~`scl_in_s`, registered.
  - The `scl_rise` timing is unchanged. `scl_sample` occurs (H>>1) counted cycles after `scl_in_s` first reads 1.
- **Simultaneous events:**
  - An `en` drop in the same cycle as the HIGH→LOW boundary is honoured: the next state is IDLE.
  - A `div` change in a boundary cycle takes effect in the new phase.

## Configuration
- Macro: `I2C_SCL_STRETCH_EN`.
- **Defined:**
  - The synchroniser and the HIGH-phase hold are built.
  - `stretching` behaves as described.
  - Nominal period = 2H+2.
- **Undefined:**
  - `scl_in` is ignored and no synchroniser flops are built.
  - `stretching` is tied to 0.
  - The high phase is exactly H cycles and the period is exactly 2H.

## Test plan
- **Reset mid-run:** drive `rst`=0 while in LOW with `bit_idx`=5 → in the same cycle `scl`=1, `scl_oe`=0, `busy`=0, `bit_idx`=0 and all strobes 0. After release with `en`=1 → `scl_fall` one cycle later.
- **Nominal clocking (macro undefined), `div`=4, `en`=1 at t:**
  - `scl_fall` at t+1, `scl_drive` at t+3, `scl_rise` at t+5, `scl_sample` at t+7.
  - Next `scl_fall` at t+9, giving an 8-cycle period.
- **Clamp and retune:** `div`=0 → period 4. Change `div` 0→6 mid-LOW → the current LOW stays at 2 cycles and the following HIGH is 6 cycles.
- **Graceful stop:** drop `en` at the cycle of `scl_drive` → LOW and HIGH complete (4+4 with `div`=4), then IDLE with `scl`=1, `busy`=0 and `bit_idx`=0.
- **Byte framing:** 10 continuous cycles → `bit_idx` runs 0,1..8,0. `byte_done` pulses once, coincident with the 10th `scl_fall`.
- **Stretching (macro defined), `div`=4:**
  - Hold `scl_in`=0 for 10 cycles after `scl_rise` → `stretching`=1 for those cycles plus 2 synchroniser cycles.
  - `scl_sample` occurs 2 counted cycles after `scl_in_s` rises, and the high phase ends 4 counted cycles after that.
  - With `scl_in` following `scl` (no stretch) → period is 10 cycles.
